// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_DATA_W    = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Tick index within a bit period: offs=0 is mid-bit, -1/+1 are its neighbours.
    function automatic int samp_idx(input int os, input int offs);
        return os / 2 - 1 + offs;
    endfunction

    localparam int SAMP_EARLY_DEF = OVERSAMPLE_DEF / 2 - 2;
    localparam int SAMP_MID_DEF   = OVERSAMPLE_DEF / 2 - 1;
    localparam int SAMP_LATE_DEF  = OVERSAMPLE_DEF / 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: dout is the head entry while not empty, 0 when empty.
// Latency: a push is visible on dout/empty one clk later.
// Backpressure: push is refused when full unless a pop happens the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH      = UART_DATA_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: 2-flop sync, OVERSAMPLE-x deframer, show-ahead receive FIFO.
// Latency: byte reaches rx_data 1 clk after the stop-bit sample; UART_RX_MAJORITY_EN votes ticks mid-1..mid+1.
// Backpressure: none on the line; a full FIFO drops the byte and sets overrun unless rd_en pops that cycle.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   RSTn,
    input  logic                   clk_uart,
    input  logic                   RXD,
    input  logic                   rd_en,
    input  logic                   err_clr,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_empty,
    output logic                   rx_full,
    output logic                   overrun,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(UART_DATA_W + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_EARLY = TW'(samp_idx(OVERSAMPLE, -1));
    localparam logic [TW-1:0] T_MID   = TW'(samp_idx(OVERSAMPLE, 0));
    localparam logic [TW-1:0] T_SAMP  = TW'(samp_idx(OVERSAMPLE, 1));
`else
    localparam logic [TW-1:0] T_SAMP  = TW'(samp_idx(OVERSAMPLE, 0));
`endif

    logic                   rx_meta;
    logic                   rxs;
    logic                   rxs_d;
    logic [TW-1:0]          tcnt;
    logic [BW-1:0]          bcnt;
    logic [UART_DATA_W-1:0] shreg;
    rx_state_t              state;
    rx_state_t              state_nxt;
    logic                   samp_tick;
    logic                   wrap_tick;
    logic                   bit_val;
    logic                   shift;
    logic                   push;
    logic                   set_ovr;
    logic                   set_fe;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= RXD;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign samp_tick = clk_uart && (tcnt == T_SAMP);
    assign wrap_tick = clk_uart && (tcnt == T_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic s_early;
    logic s_mid;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else if (clk_uart) begin
            if (tcnt == T_EARLY) s_early <= rxs;
            if (tcnt == T_MID)   s_mid   <= rxs;
        end
    end

    assign bit_val = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);
`else
    assign bit_val = rxs;
`endif

    // State changes into DATA/STOP on the tick wrap so every later sample lands a full bit after the previous one.
    always_comb begin
        state_nxt = state;
        shift     = 1'b0;
        push      = 1'b0;
        set_ovr   = 1'b0;
        set_fe    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rxs_d && !rxs) state_nxt = START;
            end
            START: begin
                if (samp_tick && bit_val) state_nxt = IDLE;
                else if (wrap_tick)       state_nxt = DATA;
            end
            DATA: begin
                if (samp_tick) shift = 1'b1;
                if (wrap_tick && (bcnt == BW'(UART_DATA_W))) state_nxt = STOP;
            end
            STOP: begin
                if (samp_tick) begin
                    state_nxt = IDLE;
                    if (!bit_val)              set_fe  = 1'b1;
                    else if (!rx_full || rd_en) push   = 1'b1;
                    else                        set_ovr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            tcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)  tcnt <= '0;
            else if (clk_uart)  tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
            if (state != DATA)  bcnt <= '0;
            else if (shift)     bcnt <= bcnt + 1'b1;
            if (shift)          shreg <= {bit_val, shreg[UART_DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (set_ovr)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
            if (set_fe)       frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

    uart_rx_fifo #(
        .WIDTH      (UART_DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .RSTn  (RSTn),
        .push  (push),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames driven at 16 ticks/bit, one tick every 4 clk.
// A queue/flag model of the FIFO and sticky flags is compared every idle cycle between frames.
// Hand-computed literals pin reset values, first-byte latency and the FIFO boundary cases.
module tb_uart_rx_ctrl;

    localparam int BIT_CYC = 64;
`ifdef UART_RX_MAJORITY_EN
    localparam int D_EXP = 613;
`else
    localparam int D_EXP = 609;
`endif

    logic       clk = 1'b0;
    logic       RSTn;
    logic       clk_uart;
    logic       RXD;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_full;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   t_start = 0;
    int   d_meas  = 0;
    bit   chk_en  = 1'b0;
    bit   abort   = 1'b0;
    logic busy_prev  = 1'b0;
    logic emp_prev   = 1'b1;
    logic emp_before = 1'b0;
    logic emp_after  = 1'b1;

    logic [7:0] q[$];
    bit         m_ovr = 1'b0;
    bit         m_fe  = 1'b0;

    uart_rx_ctrl #(.OVERSAMPLE(16), .DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .clk_uart  (clk_uart),
        .RXD       (RXD),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        clk_uart = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            clk_uart = (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("empty", 32'(rx_empty), 32'(q.size() == 0));
                chk("full", 32'(rx_full), 32'(q.size() == 16));
                chk("data", 32'(rx_data), (q.size() == 0) ? 32'd0 : 32'(q[0]));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                chk("frame_err", 32'(frame_err), 32'(m_fe));
                chk("busy_idle", 32'(busy), 32'd0);
            end
        end
    end

    // Timestamps the end of each frame: busy falls on the clk right after the stop-bit sample.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (busy_prev && !busy) begin
                d_meas     = cyc - t_start;
                emp_before = emp_prev;
                emp_after  = rx_empty;
            end
            busy_prev = busy;
            emp_prev  = rx_empty;
        end
    end

    task automatic hold_bit(input logic v, input bit g);
        RXD = v;
        if (g) begin
            repeat (24) @(negedge clk);
            #1 RXD = ~v;
            repeat (4) @(negedge clk);
            #1 RXD = v;
            repeat (BIT_CYC - 28) @(negedge clk);
            #1;
        end else begin
            repeat (BIT_CYC) @(negedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit rd_co,
                              input bit clr_co, input bit glitch);
        chk_en = 1'b0;
        do begin
            @(negedge clk);
            #1;
        end while (cyc % 4 != 0);
        t_start = cyc;
        fork
            begin
                hold_bit(1'b0, 1'b0);
                for (int k = 0; k < 8; k++) hold_bit(b[k], glitch);
                hold_bit(stop, 1'b0);
                RXD = 1'b1;
            end
            begin
                if (rd_co || clr_co) begin
                    repeat (D_EXP - 1) @(negedge clk);
                    #1;
                    rd_en   = rd_co;
                    err_clr = clr_co;
                    @(negedge clk);
                    #1;
                    rd_en   = 1'b0;
                    err_clr = 1'b0;
                end
            end
        join
        if (!abort) begin
            if (clr_co) begin
                m_ovr = 1'b0;
                m_fe  = 1'b0;
            end
            if (!stop)               m_fe = 1'b1;
            else if (q.size() < 16)  q.push_back(b);
            else if (rd_co) begin
                void'(q.pop_front());
                q.push_back(b);
            end else                 m_ovr = 1'b1;
        end
        chk_en = 1'b1;
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        #1 rd_en = 1'b1;
        @(negedge clk);
        #1 rd_en = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
    endtask

    task automatic clr_err();
        @(negedge clk);
        #1 err_clr = 1'b1;
        @(negedge clk);
        #1 err_clr = 1'b0;
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_empty"}, 32'(rx_empty), 32'd1);
        chk({tag, "_full"}, 32'(rx_full), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
        chk({tag, "_fe"}, 32'(frame_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(rx_data), 32'd0);
    endtask

    task automatic reset_mid_ff();
        abort = 1'b0;
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
            begin
                repeat (5 * BIT_CYC + 20) @(negedge clk);
                #2;
                chk("pre_rst_busy", 32'(busy), 32'd1);
                RSTn  = 1'b0;
                abort = 1'b1;
                #1;
                q.delete();
                m_ovr = 1'b0;
                m_fe  = 1'b0;
                chk_reset_vals("midrst");
                repeat (4) @(negedge clk);
                #1 RSTn = 1'b1;
            end
        join
        abort = 1'b0;
    endtask

    initial begin
        RSTn    = 1'b0;
        RXD     = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        RSTn   = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_empty", 32'(rx_empty), 32'd0);
        chk("a5_latency", 32'(d_meas), 32'(D_EXP));
        chk("a5_empty_pre", 32'(emp_before), 32'd1);
        chk("a5_empty_post", 32'(emp_after), 32'd0);
        rd_pulse();
        chk("a5_popped", 32'(rx_empty), 32'd1);

        chk_en = 1'b0;
        do begin
            @(negedge clk);
            #1;
        end while (cyc % 4 != 0);
        RXD = 1'b0;
        repeat (12) @(negedge clk);
        #1 RXD = 1'b1;
        chk("glitch_busy", 32'(busy), 32'd1);
        repeat (40) @(negedge clk);
        #1;
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_empty", 32'(rx_empty), 32'd1);
        chk("glitch_fe", 32'(frame_err), 32'd0);
        chk_en = 1'b1;

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fe_set", 32'(frame_err), 32'd1);
        chk("fe_empty", 32'(rx_empty), 32'd1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fe_set_wins", 32'(frame_err), 32'd1);
        clr_err();
        chk("fe_clr", 32'(frame_err), 32'd0);

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 14) chk("not_full_15", 32'(rx_full), 32'd0);
            if (i == 15) begin
                chk("full_16", 32'(rx_full), 32'd1);
                chk("no_ovr_16", 32'(overrun), 32'd0);
            end
        end
        chk("ovr_17", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk("rd_order", 32'(rx_data), 32'(i));
            rd_pulse();
        end
        chk("drained", 32'(rx_empty), 32'd1);
        clr_err();
        chk("ovr_clr", 32'(overrun), 32'd0);

        for (int i = 0; i < 16; i++) send_frame(8'(32 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("co_no_ovr", 32'(overrun), 32'd0);
        chk("co_full", 32'(rx_full), 32'd1);
        chk("co_head", 32'(rx_data), 32'h21);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("co_last", 32'(rx_data), 32'h10);
            rd_pulse();
        end

        send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_mid_ff();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", 32'(rx_data), 32'h81);
        rd_pulse();

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("maj_data", 32'(rx_data), 32'h5A);
        chk("maj_fe", 32'(frame_err), 32'd0);
        rd_pulse();
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Serial receive side of the SoC UART. Pairs with the transmit block on the same baud-tick source.
- Samples the incoming serial line at 16x oversampling and deframes 8N1 characters (1 start bit, 8 data bits LSB first, 1 stop bit).
- Good bytes are pushed into a show-ahead receive FIFO, which the AHB/APB UART wrapper drains.
- Reports overrun and framing errors as sticky flags, cleared by the wrapper.

Parameters:
- OVERSAMPLE, 16: clk_uart ticks per bit period; the counter width is log2 of this value.
- DEPTH_LOG2, 4: log2 of the receive FIFO depth; the default is 16 entries.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- RSTn  input  1  asynchronous active-low reset.
- clk_uart  input  1  single-cycle enable pulse at OVERSAMPLE x baud rate, from the baud generator.
- RXD  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pop the FIFO head; ignored when the FIFO is empty.
- err_clr  input  1  clears the overrun and frame_err flags.
- rx_data  output  8  FIFO head byte (show-ahead); valid only while rx_empty=0.
- rx_empty  output  1  FIFO holds no bytes.
- rx_full  output  1  FIFO holds 2^DEPTH_LOG2 bytes.
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE (mirrors bps_en style).

Behaviour:
- Reset (asynchronous, RSTn=0):
  - Synchronizer flops and the previous-sample flop load 1.
  - FSM goes to IDLE; bit counter and tick counter clear.
  - FIFO is emptied.
  - Outputs: rx_empty=1, rx_full=0, overrun=0, frame_err=0, busy=0, rx_data=0.
  - Reset mid-frame abandons the frame; no partial byte is written.
- Synchronizer: RXD passes through 2 flops to give rxs. A third flop holds rxs_d. Every decision uses rxs only.
- Tick counter tcnt:
  - Advances only on cycles where clk_uart=1.
  - Wraps from OVERSAMPLE-1 to 0.
  - Cleared on entry to START and on entry to DATA.
- Sample point: taken on the clk_uart pulse at tcnt==OVERSAMPLE/2-1 (7 at default).
- FSM states and transitions:
  - IDLE: on falling edge (rxs_d=1, rxs=0) go to START, tcnt=0. A low line with no preceding high (break) does not trigger a start.
  - START: at the sample point, rxs=0 goes to DATA with bcnt=0 and tcnt=0. rxs=1 is a false start; return to IDLE with no flag.
  - DATA: at each sample point, shift rxs into shreg[bcnt] (LSB first) and increment bcnt. After bit 7 go to STOP with tcnt=0.
  - STOP: act at the sample point, then return to IDLE immediately so the next start edge can be caught within a half bit:
    - rxs=1 and FIFO not full: push shreg.
    - rxs=1 and FIFO full with rd_en=0: drop the byte and set overrun.
    - rxs=0: set frame_err and discard the byte.
- FIFO behaviour:
  - Push when full is accepted if rd_en=1 in the same cycle (pop first, then push).
  - Push and pop together when not full: count unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2. Count width is DEPTH_LOG2+1.
  - Push latency: rx_empty falls 1 clk after the stop-bit sample point.
- Flags: err_clr clears both sticky flags. If a set event and err_clr occur in the same cycle, set wins.
- busy = (state != IDLE), registered with the FSM.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit is sampled on the ticks at tcnt = 6, 7 and 8.
  - The bit value is the 2-of-3 majority, resolved at tcnt==8. That tick replaces 7 as the sample point for every state.
  - A false start is judged on the majority result.
- Undefined: single sample at tcnt==7, with no extra sample flops.

Decomposition:
- Shared package uart_pkg holds:
  - state enum: IDLE, START, DATA, STOP;
  - UART_DATA_W=8;
  - default OVERSAMPLE=16 and the sample-index constants.
- One sub-module, uart_rx_fifo: synchronous show-ahead FIFO parameterised by width and DEPTH_LOG2, with ports push, pop, din, dout, empty, full.

Test Plan:
- Send 0xA5 at 16 ticks/bit with a tick every 4 clk -> rx_empty falls, rx_data=0xA5, flags 0; rd_en pulse -> rx_empty=1.
- Glitch RXD low for 3 ticks -> START aborts to IDLE, busy drops, FIFO stays empty, no flags.
- Send 0x3C with the stop bit forced low -> frame_err=1, FIFO empty; err_clr pulse -> frame_err=0.
- Send 17 bytes 0x00..0x10 with no reads -> rx_full=1 after the 16th, overrun=1 after the 17th; reads return 0x00..0x0F in order.
- FIFO full, then 17th stop-bit sample coincides with rd_en -> no overrun, last entry is 0x10.
- Assert RSTn low during DATA bit 4 of 0xFF -> all outputs at reset values; the next clean frame 0x81 is received correctly.
- With UART_RX_MAJORITY_EN defined, invert one sample (tick 6) per bit of 0x5A -> 0x5A is received with no flags.
